// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver that pairs with uart_tx.
// The line is double-synchronized, a falling edge starts a frame, and the
// start bit is re-checked at mid-bit. Each later bit is sampled one full bit
// period after the previous sample.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, a parity bit
// is expected between the data bits and the stop bit.
// Ports:
//   i_Clock         system clock, rising edge
//   i_Rst_n         asynchronous active-low reset
//   i_Rx_Serial     asynchronous serial line, idles high
//   o_Rx_DV         1-cycle strobe: o_Rx_Byte is valid and error-free
//   o_Rx_Byte       last good byte, held until the next good byte
//   o_Rx_Active     high from start-bit validation until the return to IDLE
//   o_Rx_Frame_Err  1-cycle strobe: the stop bit was sampled 0
//   o_Rx_Parity_Err 1-cycle strobe: parity mismatch (constant 0 without the macro)
module uart_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Parity_Err
);

    localparam logic [10:0] CNT_MID  = 11'((CLKS_PER_BIT - 1) / 2);
    localparam logic [10:0] CNT_FULL = 11'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CLEANUP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  byte_q, byte_d;
    logic        meta_q, meta_d;
    logic        sync_q, sync_d;
    logic        prev_q, prev_d;
    logic        dv_q, dv_d;
    logic        ferr_q, ferr_d;
    logic        active_q, active_d;
`ifdef UART_RX_PARITY_EN
    logic        perr_q, perr_d;
    logic        par_bad_q, par_bad_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        byte_d   = byte_q;
        active_d = active_q;
        dv_d     = 1'b0;
        ferr_d   = 1'b0;
        meta_d   = i_Rx_Serial;
        sync_d   = meta_q;
        prev_d   = sync_q;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                // Edge-triggered so that a line stuck low cannot start repeated frames.
                if (prev_q && !sync_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!sync_q) begin
                        active_d = 1'b1;
                        state_d  = S_DATA;
                    end else begin
                        state_d = S_IDLE;  // glitch shorter than half a bit
                    end
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d         = '0;
                    data_d[idx_q] = sync_q;
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d     = '0;
                    par_bad_d = ((^data_q) ^ sync_q) != PARITY_ODD;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    state_d = S_CLEANUP;
                    // A framing error takes priority over a parity error.
                    if (!sync_q) begin
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        dv_d   = 1'b1;
                        byte_d = data_q;
                    end
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_CLEANUP: begin
                active_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                active_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            byte_q   <= '0;
            meta_q   <= 1'b1;
            sync_q   <= 1'b1;
            prev_q   <= 1'b1;
            dv_q     <= 1'b0;
            ferr_q   <= 1'b0;
            active_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            byte_q   <= byte_d;
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            dv_q     <= dv_d;
            ferr_q   <= ferr_d;
            active_q <= active_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign o_Rx_DV        = dv_q;
    assign o_Rx_Byte      = byte_q;
    assign o_Rx_Active    = active_q;
    assign o_Rx_Frame_Err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign o_Rx_Parity_Err = perr_q;
`else
    assign o_Rx_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks per bit.
module tb_uart_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       dv, act, ferr, perr;
    logic [7:0] rbyte;

    int tests = 0;
    int fails = 0;

    int         dv_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
    int         long_cnt = 0, excl_cnt = 0;
    bit         act_seen = 1'b0;
    logic [7:0] got_q[$];
    logic       dv_prev = 1'b0, ferr_prev = 1'b0, perr_prev = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
        .i_Clock        (clk),
        .i_Rst_n        (rst_n),
        .i_Rx_Serial    (rx),
        .o_Rx_DV        (dv),
        .o_Rx_Byte      (rbyte),
        .o_Rx_Active    (act),
        .o_Rx_Frame_Err (ferr),
        .o_Rx_Parity_Err(perr)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (dv) begin
            dv_cnt++;
            got_q.push_back(rbyte);
        end
        if (ferr) ferr_cnt++;
        if (perr) perr_cnt++;
        if (act) act_seen = 1'b1;
        if ((dv && dv_prev) || (ferr && ferr_prev) || (perr && perr_prev)) long_cnt++;
        if (int'(dv) + int'(ferr) + int'(perr) > 1) excl_cnt++;
        dv_prev   = dv;
        ferr_prev = ferr;
        perr_prev = perr;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        dv_cnt   = 0;
        ferr_cnt = 0;
        perr_cnt = 0;
        act_seen = 1'b0;
        got_q.delete();
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    // One frame: start, 8 data bits LSB first, [parity], stop.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ 1'b0 ^ par_flip);
`else
        if (par_flip) $display("[TB] note: parity flip ignored in 8N1 build");
`endif
        send_bit(stop_v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got_q.size()) return {24'h0, got_q[i]};
        return 32'hxxxx_xxxx;
    endfunction

    initial begin
        // Reset state
        rx    = 1'b1;
        rst_n = 1'b0;
        tick(3);
        check("rst_byte",   rbyte, 8'h00);
        check("rst_dv",     dv,    1'b0);
        check("rst_active", act,   1'b0);
        check("rst_ferr",   ferr,  1'b0);
        check("rst_perr",   perr,  1'b0);
        rst_n = 1'b1;
        tick(5);

        // 1: single byte 0xA5
        clear_mon();
        send_frame(8'hA5, 1'b1, 1'b0);
        tick(4);
        check("t1_dv_cnt",  dv_cnt,   1);
        check("t1_byte",    got_at(0), 8'hA5);
        check("t1_ferr",    ferr_cnt, 0);
        check("t1_act_seen", act_seen, 1'b1);
        check("t1_act_idle", act,      1'b0);
        check("t1_hold",    rbyte,    8'hA5);

        // 2: back-to-back 0x00, 0xFF
        clear_mon();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        tick(4);
        check("t2_dv_cnt", dv_cnt,    2);
        check("t2_byte0",  got_at(0), 8'h00);
        check("t2_byte1",  got_at(1), 8'hFF);
        check("t2_ferr",   ferr_cnt,  0);

        // 3: 2-clock glitch, then 0x3C
        clear_mon();
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(20);
        check("t3_glitch_dv",  dv_cnt,   0);
        check("t3_glitch_act", act_seen, 1'b0);
        check("t3_glitch_ferr", ferr_cnt, 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        tick(4);
        check("t3_dv_cnt", dv_cnt,    1);
        check("t3_byte",   got_at(0), 8'h3C);

        // 4: framing error, then line stuck low
        clear_mon();
        send_frame(8'h81, 1'b0, 1'b0);
        rx = 1'b0;
        tick(10);
        check("t4_ferr_cnt", ferr_cnt, 1);
        check("t4_dv_cnt",   dv_cnt,   0);
        check("t4_byte",     rbyte,    8'h3C);
        clear_mon();
        tick(20 * CPB - 10);
        check("t4_no_rearm_act",  act_seen, 1'b0);
        check("t4_no_rearm_ferr", ferr_cnt, 0);
        check("t4_no_rearm_dv",   dv_cnt,   0);
        rx = 1'b1;
        tick(CPB);
        send_frame(8'h81, 1'b1, 1'b0);
        tick(4);
        check("t4_rearm_dv",   dv_cnt,    1);
        check("t4_rearm_byte", got_at(0), 8'h81);

        // 5: reset during data bit 4 of 0x5A, then 0x42
        clear_mon();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
        rx = 1'b1;  // bit 4 of 0x5A
        tick(CPB / 2);
        rst_n = 1'b0;
        tick(3);
        check("t5_rst_byte", rbyte, 8'h00);
        check("t5_rst_act",  act,   1'b0);
        rst_n = 1'b1;
        tick(2 * CPB);
        check("t5_abort_dv",   dv_cnt,   0);
        check("t5_abort_ferr", ferr_cnt, 0);
        check("t5_byte_zero",  rbyte,    8'h00);
        send_frame(8'h42, 1'b1, 1'b0);
        tick(4);
        check("t5_dv_cnt", dv_cnt,    1);
        check("t5_byte",   got_at(0), 8'h42);

`ifdef UART_RX_PARITY_EN
        // 6: even parity, good then bad parity on 0x07
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b0);
        tick(4);
        check("t6_good_dv",   dv_cnt,    1);
        check("t6_good_byte", got_at(0), 8'h07);
        check("t6_good_perr", perr_cnt,  0);
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b1);
        tick(4);
        check("t6_bad_perr", perr_cnt, 1);
        check("t6_bad_dv",   dv_cnt,   0);
        clear_mon();
        send_frame(8'h07, 1'b0, 1'b1);
        rx = 1'b1;
        tick(4);
        check("t6_both_ferr", ferr_cnt, 1);
        check("t6_both_perr", perr_cnt, 0);
`else
        check("t6_perr_cnt", perr_cnt, 0);
`endif

        // Strobe-shape invariants over the whole run
        check("strobe_width", long_cnt, 0);
        check("strobe_excl",  excl_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver, the receive-side companion of the existing uart_tx. It samples the asynchronous serial line at mid-bit using a CLKS_PER_BIT counter and delivers each byte with a 1-cycle valid strobe. It reports framing errors, and optionally parity errors, to the host-side logic. Line format is identical to uart_tx: start 0, 8 data bits LSB first, stop 1, optional parity bit between data and stop.

Parameters:
CLKS_PER_BIT, 87, clocks per bit (10 MHz / 115200); legal range 4..2047; counter is 11 bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_RX_PARITY_EN is defined.

Ports:
i_Clock  input  1  system clock, rising edge
i_Rst_n  input  1  asynchronous active-low reset
i_Rx_Serial  input  1  asynchronous serial line, idles high
o_Rx_DV  output  1  1-cycle strobe: o_Rx_Byte valid, no error
o_Rx_Byte  output  8  last received byte; held until next good byte
o_Rx_Active  output  1  high from start-bit validation until return to IDLE
o_Rx_Frame_Err  output  1  1-cycle strobe: stop bit sampled 0
o_Rx_Parity_Err  output  1  1-cycle strobe: parity mismatch (tied 0 without macro)

Behaviour:
- Reset (async assert, sync release): state IDLE, counters 0, sync flops 1, o_Rx_Byte 0x00, all strobes 0, o_Rx_Active 0.
- Input sync: 2-flop synchronizer, reset value 1. Plus one history flop for edge detect. All decisions use synchronized values.
- IDLE:
  - Counter and bit index cleared.
  - On a falling edge (prev 1, current 0), go to START and clear the counter.
  - A line held low does not re-arm; a high must be seen first.
- START:
  - Count to (CLKS_PER_BIT-1)/2 (43 at default), then sample.
  - If the sample is 0: validate the start bit, set o_Rx_Active, clear the counter, go to DATA.
  - If the sample is 1: treat as a glitch and return to IDLE with no strobe.
- DATA:
  - Count to CLKS_PER_BIT-1, sample into bit[index], clear the counter.
  - index 0..7, LSB first.
  - After index 7, go to PARITY if the macro is defined, else STOP.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample.
  - Sample 1 and no parity error: load o_Rx_Byte, pulse o_Rx_DV.
  - Sample 0: pulse o_Rx_Frame_Err. o_Rx_Byte is not updated and o_Rx_DV stays 0.
  - Either way go to CLEANUP.
- CLEANUP:
  - One cycle, strobes deassert, o_Rx_Active goes 0, return to IDLE.
  - Sampling the stop bit at mid-bit leaves half a bit to re-arm, so back-to-back frames are received.
- Strobes are exactly 1 cycle. The error strobes and o_Rx_DV are mutually exclusive.
- Latency: o_Rx_DV rises 1 clock after the stop-bit sample, about 9.5 bit times plus 3 sync/edge clocks after the line falls.
- Reset mid-frame: immediate return to IDLE. No strobe, o_Rx_Byte becomes 0x00. The first falling edge after release starts a fresh frame.
- Illegal state encoding: go to IDLE next cycle.

Optional Feature:
UART_RX_PARITY_EN
- Defined: a PARITY state is inserted after DATA. It counts CLKS_PER_BIT-1 and samples the parity bit.
  - Even parity (PARITY_ODD=0): the XOR of the 8 data bits and the parity bit must be 0.
  - Odd parity (PARITY_ODD=1): that XOR must be 1.
  - On mismatch, the STOP state pulses o_Rx_Parity_Err instead of o_Rx_DV, and o_Rx_Byte is not updated.
  - If the stop bit is also 0, only o_Rx_Frame_Err pulses.
- Undefined: there is no PARITY state, the frame is 10 bits, and o_Rx_Parity_Err is constant 0.

Test Plan:
1. CLKS_PER_BIT=8; drive 0xA5 8N1 at exactly 8 clocks/bit -> one o_Rx_DV pulse with o_Rx_Byte=0xA5; o_Rx_Active high for the frame, Frame_Err 0.
2. Back-to-back 0x00 then 0xFF with no idle gap -> two DV pulses, bytes 0x00 then 0xFF in order, no errors.
3. Line low for 2 clocks, then high (glitch shorter than half a bit) -> no strobe, o_Rx_Active never asserts, state back to IDLE; a following 0x3C is received correctly.
4. Send 0x81 with stop bit forced 0, line then held low for 20 bit times -> one Frame_Err pulse, no DV, o_Rx_Byte unchanged; no second frame until the line goes high then low.
5. Assert i_Rst_n low during data bit 4 of 0x5A, release, then send 0x42 -> no strobe for the aborted frame, o_Rx_Byte=0x00 after reset, then DV with 0x42.
6. With UART_RX_PARITY_EN and PARITY_ODD=0: send 0x07 with parity 1 -> DV with 0x07; send 0x07 with parity 0 -> Parity_Err pulse, no DV.
